// File: rtl/seg7_capture_decoder.sv
// Debounces the 7-segment bus, decodes each newly stable glyph to a hex nibble and queues it
// behind a valid/ready FIFO. Define SEG7_ACTIVE_LOW_EN for a common-anode (0=lit) bus.
module seg7_capture_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int FIFO_DEPTH    = 4,
  localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [6:0]    seg_in,
  input  logic          sample_en,
  input  logic          out_ready,
  input  logic          clear_overflow,
  output logic          out_valid,
  output logic [3:0]    out_digit,
  output logic          out_blank,
  output logic          out_invalid,
  output logic [CW-1:0] fifo_count,
  output logic          overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int RW = $clog2(STABLE_CYCLES + 1);

  typedef struct packed {
    logic       invalid;
    logic       blank;
    logic [3:0] digit;
  } entry_t;

  function automatic entry_t decode(input logic [6:0] p);
    entry_t e;
    e = '0;
    case (p)
      7'h3F: e.digit = 4'h0;
      7'h06: e.digit = 4'h1;
      7'h5B: e.digit = 4'h2;
      7'h4F: e.digit = 4'h3;
      7'h66: e.digit = 4'h4;
      7'h6D: e.digit = 4'h5;
      7'h7D: e.digit = 4'h6;
      7'h07: e.digit = 4'h7;
      7'h7F: e.digit = 4'h8;
      7'h6F: e.digit = 4'h9;
      7'h77: e.digit = 4'hA;
      7'h7C: e.digit = 4'hB;
      7'h39: e.digit = 4'hC;
      7'h5E: e.digit = 4'hD;
      7'h79: e.digit = 4'hE;
      7'h71: e.digit = 4'hF;
      7'h00: e.blank = 1'b1;
      default: e.invalid = 1'b1;
    endcase
    return e;
  endfunction

  logic [6:0]    seg_s;
  logic [6:0]    seg_prev_q;
  logic [6:0]    last_q;
  logic [RW-1:0] run_q, run_d;
  entry_t        mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] count_q;
  logic          ovf_q;
  logic          commit, full, push, pop;
  entry_t        head;

`ifdef SEG7_ACTIVE_LOW_EN
  assign seg_s = ~seg_in;
`else
  assign seg_s = seg_in;
`endif

  always_comb begin
    run_d = run_q;
    if (!sample_en)
      run_d = '0;
    else if (run_q == '0 || seg_s != seg_prev_q)
      run_d = RW'(1);
    else if (run_q != RW'(STABLE_CYCLES))
      run_d = run_q + RW'(1);
  end

  // A commit happens only on the edge the run reaches its threshold, so a held glyph commits once.
  assign commit = sample_en && (run_q == RW'(STABLE_CYCLES - 1)) &&
                  (seg_s == seg_prev_q) && (seg_s != last_q);
  assign full   = (count_q == CW'(FIFO_DEPTH));
  assign pop    = (count_q != '0) && out_ready;
  assign push   = commit && (!full || pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_prev_q <= '0;
      last_q     <= '0;
      run_q      <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
    end else begin
      seg_prev_q <= seg_s;
      run_q      <= run_d;
      if (commit) last_q <= seg_s;
      if (push)   wr_q   <= wr_q + PW'(1);
      if (pop)    rd_q   <= rd_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      // Setting takes priority over a same-cycle clear.
      if (commit && !push)
        ovf_q <= 1'b1;
      else if (clear_overflow)
        ovf_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= decode(seg_s);
  end

  assign head        = mem_q[rd_q];
  assign out_valid   = (count_q != '0);
  assign out_digit   = out_valid ? head.digit : 4'h0;
  assign out_blank   = out_valid & head.blank;
  assign out_invalid = out_valid & head.invalid;
  assign fifo_count  = count_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_seg7_capture_decoder.sv
// Directed bench: stimulus pushes expected entries {invalid,blank,digit}; a negedge monitor
// pops and compares every entry the DUT hands over.
module tb_seg7_capture_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] seg_in;
  logic       sample_en;
  logic       out_ready;
  logic       clear_overflow;
  logic       out_valid;
  logic [3:0] out_digit;
  logic       out_blank;
  logic       out_invalid;
  logic [2:0] fifo_count;
  logic       overflow;

  logic [5:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  seg7_capture_decoder #(.STABLE_CYCLES(4), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .seg_in(seg_in), .sample_en(sample_en),
    .out_ready(out_ready), .clear_overflow(clear_overflow),
    .out_valid(out_valid), .out_digit(out_digit), .out_blank(out_blank),
    .out_invalid(out_invalid), .fifo_count(fifo_count), .overflow(overflow)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_seg(input logic [6:0] p);
`ifdef SEG7_ACTIVE_LOW_EN
    seg_in = ~p;
`else
    seg_in = p;
`endif
  endtask

  function automatic logic [5:0] ent(input logic inv, input logic blk, input logic [3:0] d);
    return {inv, blk, d};
  endfunction

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_entry: got %0h expected none",
                 {out_invalid, out_blank, out_digit});
      end else begin
        logic [5:0] e;
        e = exp_q.pop_front();
        if ({out_invalid, out_blank, out_digit} === e) n_pass++;
        else $display("FAIL entry: got %0h expected %0h",
                      {out_invalid, out_blank, out_digit}, e);
      end
    end
  end

  initial begin
    logic [6:0] fill_a [5];
    logic [6:0] fill_b [4];
    fill_a = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66};
    fill_b = '{7'h7D, 7'h07, 7'h7F, 7'h6F};

    rst = 1'b1; sample_en = 1'b1; out_ready = 1'b0; clear_overflow = 1'b0;
    set_seg(7'h00);
    step(2);
    chk("rst_valid", out_valid, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_digit", out_digit, 0);

    // 1: latency of a single commit
    rst = 1'b0;
    set_seg(7'h06);
    step(3);
    chk("lat_count_before", fifo_count, 0);
    step(1);
    chk("lat_count", fifo_count, 1);
    chk("lat_valid", out_valid, 1);
    chk("lat_digit", out_digit, 1);
    exp_q.push_back(ent(0, 0, 4'h1));
    out_ready = 1'b1;
    step(2);

    // 2: short glitch is ignored
    set_seg(7'h5B);
    step(2);
    set_seg(7'h4F);
    exp_q.push_back(ent(0, 0, 4'h3));
    step(6);
    chk("glitch_count", fifo_count, 0);

    // 3: overflow on a full FIFO, then drain and clear
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) exp_q.push_back(ent(0, 0, 4'(i)));
    for (int i = 0; i < 5; i++) begin
      set_seg(fill_a[i]);
      step(5);
    end
    chk("full_count", fifo_count, 4);
    chk("full_overflow", overflow, 1);
    out_ready = 1'b1;
    step(6);
    chk("drain_count", fifo_count, 0);
    chk("ovf_sticky", overflow, 1);
    clear_overflow = 1'b1;
    step(1);
    clear_overflow = 1'b0;
    chk("ovf_cleared", overflow, 0);

    // 3b: commit into a full FIFO in the same cycle as a pop
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_seg(fill_b[i]);
      exp_q.push_back(ent(0, 0, 4'(6 + i)));
      step(5);
    end
    chk("refill_count", fifo_count, 4);
    set_seg(7'h77);
    exp_q.push_back(ent(0, 0, 4'hA));
    step(3);
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    chk("pop_push_count", fifo_count, 4);
    chk("pop_push_overflow", overflow, 0);
    out_ready = 1'b1;
    step(6);
    chk("pop_push_drain", fifo_count, 0);

    // 4: blank, digit, invalid
    set_seg(7'h00); exp_q.push_back(ent(0, 1, 4'h0)); step(6);
    set_seg(7'h7F); exp_q.push_back(ent(0, 0, 4'h8)); step(6);
    set_seg(7'h01); exp_q.push_back(ent(1, 0, 4'h0)); step(6);
    chk("decode_count", fifo_count, 0);

    // 5: long hold commits once; disabled monitor commits nothing
    set_seg(7'h6F); exp_q.push_back(ent(0, 0, 4'h9)); step(20);
    sample_en = 1'b0;
    set_seg(7'h06);
    step(10);
    chk("disabled_count", fifo_count, 0);
    sample_en = 1'b1;
    exp_q.push_back(ent(0, 0, 4'h1));
    step(6);
    chk("reenable_count", fifo_count, 0);

    // 6: reset discards queued entries
    out_ready = 1'b0;
    set_seg(7'h3F); step(5);
    set_seg(7'h06); step(5);
    set_seg(7'h5B); step(5);
    chk("pre_rst_count", fifo_count, 3);
    rst = 1'b1;
    set_seg(7'h00);
    step(1);
    rst = 1'b0;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_count", fifo_count, 0);
    chk("mid_rst_overflow", overflow, 0);
    out_ready = 1'b1;
    step(8);
    chk("post_rst_count", fifo_count, 0);

`ifdef SEG7_ACTIVE_LOW_EN
    seg_in = 7'h40;
    exp_q.push_back(ent(0, 0, 4'h0));
    step(6);
    chk("active_low_count", fifo_count, 0);
`endif

    step(2);
    chk("exp_q_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
